// File: rtl/mem_wr_packer.sv
// Packs a stream of SIZE-bit elements into blocks of up to BLOCK_SIZE lanes and issues each block as one memory write.
// Optional abort input is enabled by defining MEM_WR_PACKER_ABORT_EN.
module mem_wr_packer #(
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int ADDR_SIZE  = 24
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic [ADDR_SIZE-1:0]               i_base_addr,
  input  logic [ADDR_SIZE-1:0]               i_count,
  input  logic                               i_valid,
  input  logic [SIZE-1:0]                    i_data,
`ifdef MEM_WR_PACKER_ABORT_EN
  input  logic                               i_abort,
`endif
  output logic                               o_ready,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [ADDR_SIZE-1:0]               o_addr_w,
  output logic [BLOCK_SIZE-1:0][SIZE-1:0]    o_data_w,
  output logic [$clog2(BLOCK_SIZE)-1:0]      o_wr_size,
  output logic                               o_wr_en,
  output logic [1:0]                         o_state
);

  localparam int WS = $clog2(BLOCK_SIZE);
  localparam logic [WS-1:0] FULL = WS'(BLOCK_SIZE);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

  // Handshake: an element transfers on a rising edge where i_valid && o_ready;
  // o_ready depends only on state, never on i_valid.
  state_t                          state, state_n;
  logic [ADDR_SIZE-1:0]            addr_r, addr_n;
  logic [ADDR_SIZE-1:0]            rem_r, rem_n, rem_dec;
  logic [WS-1:0]                   fill_r, fill_n, fill_inc;
  logic [BLOCK_SIZE-1:0][SIZE-1:0] buf_r, buf_n;
  logic [ADDR_SIZE-1:0]            addr_w_n;
  logic [BLOCK_SIZE-1:0][SIZE-1:0] data_w_n;
  logic [WS-1:0]                   size_n;
  logic                            wr_en_n;
  logic                            abort;

`ifdef MEM_WR_PACKER_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  assign o_ready = (state == FILL);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_state = state;

  always_comb begin
    state_n  = state;
    addr_n   = addr_r;
    rem_n    = rem_r;
    fill_n   = fill_r;
    buf_n    = buf_r;
    addr_w_n = o_addr_w;
    data_w_n = o_data_w;
    size_n   = o_wr_size;
    wr_en_n  = 1'b0;
    fill_inc = fill_r + 1'b1;
    rem_dec  = rem_r - 1'b1;
    case (state)
      IDLE: begin
        if (i_start) begin
          addr_n  = i_base_addr;
          rem_n   = i_count;
          fill_n  = '0;
          buf_n   = '0;
          state_n = (i_count != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        if (abort) begin
          buf_n   = '0;
          fill_n  = '0;
          rem_n   = '0;
          state_n = IDLE;
        end else if (i_valid) begin
          // k-th element of a block lands in lane BLOCK_SIZE-1-k
          for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (fill_r == WS'(BLOCK_SIZE - 1 - i)) buf_n[i] = i_data;
          end
          rem_n = rem_dec;
          if (fill_inc == FULL || rem_dec == '0) begin
            wr_en_n  = 1'b1;
            addr_w_n = addr_r;
            size_n   = fill_inc;
            data_w_n = buf_n;
            buf_n    = '0;
            fill_n   = '0;
            addr_n   = addr_r + ADDR_SIZE'(fill_inc);
            if (rem_dec == '0) state_n = FLUSH;
          end else begin
            fill_n = fill_inc;
          end
        end
      end
      FLUSH:   state_n = abort ? IDLE : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      addr_r    <= '0;
      rem_r     <= '0;
      fill_r    <= '0;
      buf_r     <= '0;
      o_addr_w  <= '0;
      o_data_w  <= '0;
      o_wr_size <= '0;
      o_wr_en   <= 1'b0;
    end else begin
      state     <= state_n;
      addr_r    <= addr_n;
      rem_r     <= rem_n;
      fill_r    <= fill_n;
      buf_r     <= buf_n;
      o_addr_w  <= addr_w_n;
      o_data_w  <= data_w_n;
      o_wr_size <= size_n;
      o_wr_en   <= wr_en_n;
    end
  end

endmodule
